// File: rtl/fifo_ptr_pkg.sv
// Gray/binary pointer helpers shared by the read- and write-side FIFO pointer controllers.
// Functions work on a max-width vector; callers zero-extend narrower pointers and truncate results.
package fifo_ptr_pkg;

    localparam int PTR_W_MAX = 15;

    typedef logic [PTR_W_MAX:0] ptr_max_t;

    function automatic ptr_max_t bin2gray(input ptr_max_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_max_t gray2bin(input ptr_max_t g);
        ptr_max_t b;
        b = g;
        for (int i = 1; i <= PTR_W_MAX; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/rptr_ctrl_sync_if.sv
// Read-side FIFO pointer controller bundle: consumer/write-domain inputs and pointer/status outputs.
// master = consumer side driving requests, slave = the pointer controller.
interface rptr_ctrl_sync_if #(
    parameter int PTR_W = 3
);
    logic             r_en;
    logic [PTR_W:0]   g_wptr_async;
    logic [PTR_W:0]   ae_thresh;
    logic             clr_underflow;
    logic [PTR_W-1:0] raddr;
    logic [PTR_W:0]   b_rptr;
    logic [PTR_W:0]   g_rptr;
    logic             empty;
    logic             almost_empty;
    logic [PTR_W:0]   rcount;
    logic             underflow;

    modport master (
        output r_en, g_wptr_async, ae_thresh, clr_underflow,
        input  raddr, b_rptr, g_rptr, empty, almost_empty, rcount, underflow
    );

    modport slave (
        input  r_en, g_wptr_async, ae_thresh, clr_underflow,
        output raddr, b_rptr, g_rptr, empty, almost_empty, rcount, underflow
    );

endinterface

// File: rtl/sync_ff_chain.sv
// Vector flop synchroniser, STAGES deep, synchronous active-high reset to zero.
// Latency STAGES edges; no backpressure (free-running sampler).
module sync_ff_chain #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/rptr_ctrl_sync.sv
// Async FIFO read-side pointer controller: write-pointer sync, registered empty/count/almost-empty, sticky underflow.
// Reads update status at the same edge as the pointer; writes visible SYNC_STAGES+1 edges later; reads while empty are dropped.
module rptr_ctrl_sync
    import fifo_ptr_pkg::*;
#(
    parameter int PTR_W       = 3,
    parameter int SYNC_STAGES = 2
) (
    input logic              rclk,
    input logic              rrst,
    rptr_ctrl_sync_if.slave  rif
);

    localparam int PW1   = PTR_W + 1;
    localparam int DEPTH = 2 ** PTR_W;

    logic [PTR_W:0] g_wptr_sync;
    logic [PTR_W:0] b_wptr_sync;
    logic [PTR_W:0] b_rptr_q;
    logic [PTR_W:0] g_rptr_q;
    logic [PTR_W:0] rcount_q;
    logic           empty_q;
    logic           almost_empty_q;
    logic           underflow_q;

    logic           rd_fire;
    logic [PTR_W:0] b_rptr_next;
    logic [PTR_W:0] g_rptr_next;
    logic [PTR_W:0] rcount_next;
    logic           empty_next;
    logic           almost_empty_next;
    logic           underflow_next;

    sync_ff_chain #(
        .WIDTH  (PW1),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk (rclk),
        .rst (rrst),
        .d   (rif.g_wptr_async),
        .q   (g_wptr_sync)
    );

    always_comb begin
        b_wptr_sync = PW1'(gray2bin(ptr_max_t'(g_wptr_sync)));
        rd_fire     = rif.r_en && !empty_q;
        b_rptr_next = b_rptr_q + {{PTR_W{1'b0}}, rd_fire};
        g_rptr_next = PW1'(bin2gray(ptr_max_t'(b_rptr_next)));
        // Count uses the freshly synchronised write pointer and the post-read pointer together.
        rcount_next       = b_wptr_sync - b_rptr_next;
        empty_next        = (g_rptr_next == g_wptr_sync);
        almost_empty_next = (rcount_next <= rif.ae_thresh);
        // A new underflow wins over a same-cycle clear.
        if (rif.r_en && empty_q) begin
            underflow_next = 1'b1;
        end else if (rif.clr_underflow) begin
            underflow_next = 1'b0;
        end else begin
            underflow_next = underflow_q;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            b_rptr_q       <= '0;
            g_rptr_q       <= '0;
            rcount_q       <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            underflow_q    <= 1'b0;
        end else begin
            b_rptr_q       <= b_rptr_next;
            g_rptr_q       <= g_rptr_next;
            rcount_q       <= rcount_next;
            empty_q        <= empty_next;
            almost_empty_q <= almost_empty_next;
            underflow_q    <= underflow_next;
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst) begin
            assert (32'(rcount_q) <= DEPTH);
        end
    end

    assign rif.raddr        = b_rptr_q[PTR_W-1:0];
    assign rif.b_rptr       = b_rptr_q;
    assign rif.g_rptr       = g_rptr_q;
    assign rif.rcount       = rcount_q;
    assign rif.empty        = empty_q;
    assign rif.almost_empty = almost_empty_q;
    assign rif.underflow    = underflow_q;

endmodule

// File: tb/tb_rptr_ctrl_sync.sv
// Bench for rptr_ctrl_sync (PTR_W=3, SYNC_STAGES=2): directed plan steps, then random traffic vs an occupancy model.
module tb_rptr_ctrl_sync;

    localparam int PW  = 3;
    localparam int SS  = 2;
    localparam int MOD = 16;
    localparam int DEP = 8;

    logic rclk = 1'b0;
    logic rrst;

    always #5 rclk = ~rclk;

    rptr_ctrl_sync_if #(.PTR_W(PW)) rif ();

    rptr_ctrl_sync #(
        .PTR_W       (PW),
        .SYNC_STAGES (SS)
    ) dut (
        .rclk (rclk),
        .rrst (rrst),
        .rif  (rif)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: write pointer as a plain counter, history of what the sync chain has sampled.
    int wbin   = 0;
    int m_rptr = 0;
    int m_cnt  = 0;
    bit m_empty = 1'b1;
    bit m_ae    = 1'b1;
    bit m_uf    = 1'b0;
    int hist[$];
    int sync_guard = 0;
    logic [3:0] prev_sync = '0;
    int th_tab[5] = '{0, 2, 5, 8, 15};

    function automatic logic [3:0] gray(input int v);
        logic [3:0] b;
        b = v[3:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int ws;
        int th;
        @(posedge rclk);
        th = int'(rif.ae_thresh);
        if (rrst) begin
            hist.delete();
            repeat (SS) hist.push_back(0);
            m_rptr  = 0;
            m_cnt   = 0;
            m_empty = 1'b1;
            m_ae    = 1'b1;
            m_uf    = 1'b0;
        end else begin
            ws = hist.pop_front();
            hist.push_back(wbin);
            if (rif.r_en && m_empty) m_uf = 1'b1;
            else if (rif.clr_underflow) m_uf = 1'b0;
            if (rif.r_en && !m_empty) m_rptr = (m_rptr + 1) % MOD;
            m_cnt   = (ws - m_rptr + MOD) % MOD;
            m_empty = (m_cnt == 0);
            m_ae    = (m_cnt <= th);
        end
        #1;
        chk("m_b_rptr",       32'(rif.b_rptr),       32'(m_rptr));
        chk("m_g_rptr",       32'(rif.g_rptr),       32'(gray(m_rptr)));
        chk("m_raddr",        32'(rif.raddr),        32'(m_rptr % DEP));
        chk("m_rcount",       32'(rif.rcount),       32'(m_cnt));
        chk("m_empty",        32'(rif.empty),        32'(m_empty));
        chk("m_almost_empty", 32'(rif.almost_empty), 32'(m_ae));
        chk("m_underflow",    32'(rif.underflow),    32'(m_uf));
        // A reset legitimately makes the synced pointer jump; only check settled, reset-free spans.
        if (rrst) sync_guard = SS + 1;
        else if (sync_guard > 0) sync_guard--;
        else chk("sync_gray_step", 32'($countones(dut.g_wptr_sync ^ prev_sync) <= 1), 32'd1);
        prev_sync = dut.g_wptr_sync;
    endtask

    task automatic advance(input int target);
        while (wbin != target) begin
            wbin = (wbin + 1) % MOD;
            rif.g_wptr_async = gray(wbin);
            tick();
        end
    endtask

    initial begin
        rrst = 1'b1;
        rif.r_en = 1'b0;
        rif.clr_underflow = 1'b0;
        rif.ae_thresh = 4'd2;
        rif.g_wptr_async = gray(0);

        // 1. reset
        tick(); tick();
        chk("rst_empty",  32'(rif.empty), 32'd1);
        chk("rst_ae",     32'(rif.almost_empty), 32'd1);
        chk("rst_rcount", 32'(rif.rcount), 32'd0);
        chk("rst_b_rptr", 32'(rif.b_rptr), 32'd0);
        chk("rst_g_rptr", 32'(rif.g_rptr), 32'd0);
        chk("rst_uf",     32'(rif.underflow), 32'd0);
        rrst = 1'b0;

        // 2. single word, write-to-visible latency
        wbin = 1;
        rif.g_wptr_async = gray(1);
        tick(); tick();
        chk("lat_empty_e2", 32'(rif.empty), 32'd1);
        tick();
        chk("lat_empty_e3",  32'(rif.empty), 32'd0);
        chk("lat_rcount_e3", 32'(rif.rcount), 32'd1);
        rif.r_en = 1'b1;
        tick();
        rif.r_en = 1'b0;
        chk("rd1_b_rptr", 32'(rif.b_rptr), 32'd1);
        chk("rd1_g_rptr", 32'(rif.g_rptr), 32'b0001);
        chk("rd1_empty",  32'(rif.empty), 32'd1);
        chk("rd1_rcount", 32'(rif.rcount), 32'd0);

        // 3. fill to full depth, almost-empty threshold 2
        advance(9);
        repeat (SS) tick();
        chk("full_rcount", 32'(rif.rcount), 32'd8);
        chk("full_ae",     32'(rif.almost_empty), 32'd0);
        rif.r_en = 1'b1;
        repeat (5) tick();
        chk("rd5_ae", 32'(rif.almost_empty), 32'd0);
        tick();
        chk("rd6_rcount", 32'(rif.rcount), 32'd2);
        chk("rd6_ae",     32'(rif.almost_empty), 32'd1);
        tick(); tick();
        chk("drain_empty",  32'(rif.empty), 32'd1);
        chk("drain_b_rptr", 32'(rif.b_rptr), 32'd9);

        // 4. underflow (r_en still high on empty)
        chk("uf_pre", 32'(rif.underflow), 32'd0);
        tick();
        chk("uf_b_rptr_hold", 32'(rif.b_rptr), 32'd9);
        chk("uf_set", 32'(rif.underflow), 32'd1);
        rif.r_en = 1'b0;
        repeat (3) tick();
        chk("uf_sticky", 32'(rif.underflow), 32'd1);
        rif.r_en = 1'b1;
        rif.clr_underflow = 1'b1;
        tick();
        chk("uf_set_beats_clr", 32'(rif.underflow), 32'd1);
        rif.r_en = 1'b0;
        tick();
        chk("uf_cleared", 32'(rif.underflow), 32'd0);
        rif.clr_underflow = 1'b0;

        // 5. pointer wrap
        advance(14);
        repeat (SS) tick();
        rif.r_en = 1'b1;
        repeat (5) tick();
        rif.r_en = 1'b0;
        chk("wrap_pre_b_rptr", 32'(rif.b_rptr), 32'd14);
        advance(2);
        repeat (SS) tick();
        chk("wrap_rcount", 32'(rif.rcount), 32'd4);
        rif.r_en = 1'b1;
        tick();
        chk("wrap_b15", 32'(rif.b_rptr), 32'd15);
        chk("wrap_g15", 32'(rif.g_rptr), 32'b1000);
        tick();
        chk("wrap_b0", 32'(rif.b_rptr), 32'd0);
        chk("wrap_g0", 32'(rif.g_rptr), 32'b0000);
        tick();
        chk("wrap_b1", 32'(rif.b_rptr), 32'd1);
        tick();
        chk("wrap_b2",    32'(rif.b_rptr), 32'd2);
        chk("wrap_empty", 32'(rif.empty), 32'd1);
        rif.r_en = 1'b0;

        // 6. mid-operation reset with write pointer held
        rrst = 1'b1;
        wbin = 0;
        rif.g_wptr_async = gray(0);
        tick();
        rrst = 1'b0;
        advance(5);
        repeat (SS) tick();
        chk("mid_pre_rcount", 32'(rif.rcount), 32'd5);
        rrst = 1'b1;
        tick();
        rrst = 1'b0;
        chk("mid_rst_empty",  32'(rif.empty), 32'd1);
        chk("mid_rst_rcount", 32'(rif.rcount), 32'd0);
        chk("mid_rst_ae",     32'(rif.almost_empty), 32'd1);
        tick(); tick();
        chk("mid_e2_empty", 32'(rif.empty), 32'd1);
        tick();
        chk("mid_e3_empty",  32'(rif.empty), 32'd0);
        chk("mid_e3_rcount", 32'(rif.rcount), 32'd5);

        // random traffic
        for (int n = 0; n < 800; n++) begin
            if (n % 100 == 0) rif.ae_thresh = 4'(th_tab[$urandom_range(0, 4)]);
            rrst = ($urandom_range(0, 99) == 0);
            if (rrst) begin
                wbin = 0;
            end else if ($urandom_range(0, 1) == 1 && ((wbin - m_rptr + MOD) % MOD) < DEP) begin
                wbin = (wbin + 1) % MOD;
            end
            rif.g_wptr_async  = gray(wbin);
            rif.r_en          = ($urandom_range(0, 1) == 1);
            rif.clr_underflow = ($urandom_range(0, 7) == 0);
            tick();
        end
        rrst = 1'b0;
        rif.r_en = 1'b0;
        rif.clr_underflow = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
